// File: rtl/fp8_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fp8_mul_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one registered FP8 multiplier among
//   NUM_REQ requesters (MAC lanes). The multiplier has one cycle of registered
//   latency and returns a 12-bit {sign, exp[3:0], mant[6:0]} product. One
//   operation is in flight at a time. Results go back on a single tagged
//   response channel that can be backpressured.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The source holds its payload stable while valid is high and ready
//   is low. ready may depend combinationally on valid. valid may drop before
//   a transfer; an ungranted request that drops leaves no trace.
//
// Ports:
//   clk        in   1          clock
//   rst        in   1          asynchronous, active-high reset
//   req_valid  in   NUM_REQ    per-requester operand valid
//   req_a      in   8*NUM_REQ  operand A of requester i at [8i+7:8i]
//   req_b      in   8*NUM_REQ  operand B of requester i at [8i+7:8i]
//   req_ready  out  NUM_REQ    one-hot grant (or all zero)
//   mul_a      out  8          registered operand A to the multiplier
//   mul_b      out  8          registered operand B to the multiplier
//   mul_out    in   12         registered multiplier result
//   rsp_valid  out  1          response valid
//   rsp_id     out  IDW        index of the requester owning the response
//   rsp_data   out  12         product, passed straight through from mul_out
//   rsp_ready  in   1          response consumer ready
//   busy       out  1          high while in ISSUE or RESP
//   ops_done   out  16         completed-response counter (wraps)
// ---------------------------------------------------------------------------
module fp8_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [11:0]          mul_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [11:0]          rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] tag_q;
    logic [7:0]     mul_a_q;
    logic [7:0]     mul_b_q;
    logic           rsp_valid_q;
    logic           busy_q;
    logic [15:0]    ops_cnt;

    logic               accept_en;
    logic               grant_any;
    logic               grant;
    logic [IDW-1:0]     grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDW-1:0]     cand;
    logic [7:0]         sel_a;
    logic [7:0]         sel_b;

    // A new operation can be taken when idle, or in the same cycle the
    // current response is consumed, so back-to-back ops have no extra bubble.
    always_comb begin
        accept_en = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    end

    // Round-robin search: start one past the last granted index and take the
    // first asserted valid. The found flag keeps the earliest hit.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any      = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        grant     = accept_en && grant_any;
        req_ready = grant ? grant_oh : '0;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[8*i +: 8];
                sel_b = req_b[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDW'(NUM_REQ - 1);
            tag_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ops_cnt     <= '0;
        end else begin
            // Operands are captured only at grant and then held, which keeps
            // mul_out stable for the whole RESP phase.
            if (grant) begin
                ptr_q   <= grant_idx;
                tag_q   <= grant_idx;
                mul_a_q <= sel_a;
                mul_b_q <= sel_b;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        state_q <= ST_ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // Multiplier registers the held operands on this edge.
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        ops_cnt     <= ops_cnt + 16'd1;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= grant;
                        state_q     <= grant ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = tag_q;
    assign rsp_data  = mul_out;
    assign busy      = busy_q;
    assign ops_done  = ops_cnt;

endmodule
